// File: rtl/caliptra_fpga_sync_pkg.sv
// Shared constants and helpers for the parametrised FPGA sync register slave.
package caliptra_fpga_sync_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Lowest address bit of the register index: the byte offset within one register is dropped.
  function automatic int unsigned idx_lsb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/caliptra_fpga_sync_wr_join.sv
// Joins the AXI4-Lite AW and W channels through one-entry holds and owns the B channel.
module caliptra_fpga_sync_wr_join
  import caliptra_fpga_sync_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic                o_bvalid,
  input  logic                i_bready,
  output logic [1:0]          o_bresp,
  input  logic [1:0]          i_cm_resp,
  output logic                o_commit,
  output logic [ADDR_W-1:0]   o_cm_addr,
  output logic [DATA_W-1:0]   o_cm_data,
  output logic [DATA_W/8-1:0] o_cm_strb
);

  logic                r_aw_held;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic                r_w_held;
  logic [DATA_W-1:0]   r_w_data;
  logic [DATA_W/8-1:0] r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                w_aw_fire;
  logic                w_w_fire;

  assign o_awready = i_rstn & ~r_aw_held & ~r_bvalid;
  assign o_wready  = i_rstn & ~r_w_held & ~r_bvalid;
  assign w_aw_fire = i_awvalid & o_awready;
  assign w_w_fire  = i_wvalid & o_wready;

  // Both holds set together never persists, so "have both" implies one of them fired this edge.
  assign o_commit  = (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
  assign o_cm_addr = r_aw_held ? r_aw_addr : i_awaddr;
  assign o_cm_data = r_w_held ? r_w_data : i_wdata;
  assign o_cm_strb = r_w_held ? r_w_strb : i_wstrb;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (r_bvalid && i_bready) r_bvalid <= 1'b0;
      if (o_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= i_cm_resp;
      end else begin
        if (w_aw_fire) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= i_awaddr;
        end
        if (w_w_fire) begin
          r_w_held <= 1'b1;
          r_w_data <= i_wdata;
          r_w_strb <= i_wstrb;
        end
      end
    end
  end

endmodule

// File: rtl/caliptra_fpga_sync_regfile.sv
// AXI4-Lite register slave with per-register RW / read-only mirror / self-clearing pulse modes.
module caliptra_fpga_sync_regfile
  import caliptra_fpga_sync_pkg::*;
#(
  parameter int unsigned           DATA_W     = 64,
  parameter int unsigned           ADDR_W     = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]   PULSE_MASK = '0
) (
  input  logic                       aclk,
  input  logic                       rstn,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic [2:0]                 arprot,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic [2:0]                 awprot,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in
);

  localparam int unsigned LSB    = idx_lsb(DATA_W);
  localparam int unsigned IDX_W  = ADDR_W - LSB;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  logic                w_commit;
  logic [ADDR_W-1:0]   w_cm_addr;
  logic [DATA_W-1:0]   w_cm_data;
  logic [STRB_W-1:0]   w_cm_strb;
  logic [1:0]          w_cm_resp;
  logic [IDX_W-1:0]    w_cm_idx;
  logic [IDX_W-1:0]    w_ar_idx;
  logic [DATA_W-1:0]   w_rd_data;
  logic [1:0]          w_rd_resp;
  logic                w_unused;

  caliptra_fpga_sync_wr_join #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_join (
    .i_clk     (aclk),
    .i_rstn    (rstn),
    .i_awvalid (awvalid),
    .o_awready (awready),
    .i_awaddr  (awaddr),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .o_bvalid  (bvalid),
    .i_bready  (bready),
    .o_bresp   (bresp),
    .i_cm_resp (w_cm_resp),
    .o_commit  (w_commit),
    .o_cm_addr (w_cm_addr),
    .o_cm_data (w_cm_data),
    .o_cm_strb (w_cm_strb)
  );

  assign w_cm_idx = w_cm_addr[ADDR_W-1:LSB];
  assign w_ar_idx = araddr[ADDR_W-1:LSB];
  assign w_unused = ^{arprot, awprot, araddr[LSB-1:0], w_cm_addr[LSB-1:0]};

  // Index compares are done per register so out-of-range indices simply match nothing.
  always_comb begin
    w_cm_resp = RESP_DECERR;
    w_rd_resp = RESP_DECERR;
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_cm_idx == IDX_W'(i)) w_cm_resp = RO_MASK[i] ? RESP_SLVERR : RESP_OKAY;
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_resp = RESP_OKAY;
        if (RO_MASK[i])         w_rd_data = reg_in[i*DATA_W +: DATA_W];
        else if (!PULSE_MASK[i]) w_rd_data = r_regs[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[i*DATA_W +: DATA_W] = r_regs[i];
  end

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (PULSE_MASK[i] && !RO_MASK[i]) r_regs[i] <= '0;
        if (w_commit && !RO_MASK[i] && (w_cm_idx == IDX_W'(i))) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_cm_strb[b]) r_regs[i][b*8 +: 8] <= w_cm_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign arready = rstn & ~r_rvalid;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_caliptra_fpga_sync_regfile.sv
// Directed self-checking bench for caliptra_fpga_sync_regfile (64-bit, 16 regs, reg 2 RO, reg 3 pulse).
module tb_caliptra_fpga_sync_regfile;

  logic          aclk = 1'b0;
  logic          rstn;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   araddr, awaddr;
  logic [2:0]    arprot, awprot;
  logic [63:0]   rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]    wstrb;
  logic [1023:0] reg_out, reg_in, snap;

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  caliptra_fpga_sync_regfile #(
    .DATA_W     (64),
    .ADDR_W     (32),
    .NUM_REGS   (16),
    .RO_MASK    (16'h0004),
    .PULSE_MASK (16'h0008)
  ) dut (
    .aclk    (aclk),
    .rstn    (rstn),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .arprot  (arprot),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .awprot  (awprot),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .reg_out (reg_out),
    .reg_in  (reg_in)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] slice(input int unsigned i);
    return reg_out[i*64 +: 64];
  endfunction

  task automatic start_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bit ad, wd, ag, wg;
    int k;
    @(negedge aclk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    ad = 0; wd = 0; k = 0;
    while (!(ad && wd) && k < 20) begin
      ag = awvalid && awready;
      wg = wvalid && wready;
      @(posedge aclk);
      @(negedge aclk);
      if (ag) begin ad = 1; awvalid = 1'b0; end
      if (wg) begin wd = 1; wvalid = 1'b0; end
      k++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", 64'(ad && wd), 64'd1);
    chk("bvalid_lat", 64'(bvalid), 64'd1);
  endtask

  task automatic finish_write(output logic [1:0] resp);
    resp = bresp;
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_drop", 64'(bvalid), 64'd0);
  endtask

  task automatic start_read(input logic [31:0] a);
    bit ag, done;
    int k;
    @(negedge aclk);
    arvalid = 1'b1; araddr = a;
    done = 0; k = 0;
    while (!done && k < 20) begin
      ag = arvalid && arready;
      @(posedge aclk);
      @(negedge aclk);
      if (ag) begin done = 1; arvalid = 1'b0; end
      k++;
    end
    arvalid = 1'b0;
    chk("rd_handshake", 64'(done), 64'd1);
    chk("rvalid_lat", 64'(rvalid), 64'd1);
  endtask

  task automatic finish_read(output logic [63:0] d, output logic [1:0] resp);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 1'b0;
    chk("rvalid_drop", 64'(rvalid), 64'd0);
    chk("arready_after", 64'(arready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    rstn = 1'b0;
    arvalid = 0; araddr = '0; arprot = '0; rready = 0;
    awvalid = 0; awaddr = '0; awprot = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    reg_in = '0;
    reg_in[2*64 +: 64] = 64'h0000_0000_0000_CAFE;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_regs", 64'(|reg_out), 64'd0);
    rstn = 1'b1;
    #1;
    chk("post_arready", 64'(arready), 64'd1);
    chk("post_awready", 64'(awready), 64'd1);
    chk("post_wready", 64'(wready), 64'd1);

    // Basic write/read of reg 1
    start_write(32'h08, 64'h1122_3344_5566_7788, 8'hFF);
    chk("w1_regout", slice(1), 64'h1122_3344_5566_7788);
    finish_write(r);
    chk("w1_bresp", 64'(r), 64'd0);
    start_read(32'h08);
    finish_read(d, r);
    chk("r1_data", d, 64'h1122_3344_5566_7788);
    chk("r1_resp", 64'(r), 64'd0);
    start_read(32'h0C);
    finish_read(d, r);
    chk("r1_offset", d, 64'h1122_3344_5566_7788);

    // Read and write commit to reg 1 on the same edge: read sees old value
    @(negedge aclk);
    arvalid = 1; araddr = 32'h08;
    awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF;
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk("same_rvalid", 64'(rvalid), 64'd1);
    chk("same_rdata", rdata, 64'h1122_3344_5566_7788);
    chk("same_bvalid", 64'(bvalid), 64'd1);
    chk("same_regout", slice(1), 64'h0123_4567_89AB_CDEF);
    rready = 1; bready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0; bready = 0;

    // Byte strobes on reg 4
    start_write(32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    finish_write(r);
    start_read(32'h20);
    finish_read(d, r);
    chk("strb_lo", d, 64'h0000_0000_FFFF_FFFF);
    start_write(32'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0);
    finish_write(r);
    start_read(32'h20);
    finish_read(d, r);
    chk("strb_hi", d, 64'hAAAA_AAAA_FFFF_FFFF);

    // W accepted 3 cycles before AW (reg 5)
    @(negedge aclk);
    wvalid = 1; wdata = 64'h5555_0000_5555_0000; wstrb = 8'hFF;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 0;
    chk("wf_wready", 64'(wready), 64'd0);
    chk("wf_bvalid", 64'(bvalid), 64'd0);
    repeat (2) @(negedge aclk);
    chk("wf_wready2", 64'(wready), 64'd0);
    chk("wf_reg_unch", slice(5), 64'd0);
    awvalid = 1; awaddr = 32'h28;
    chk("wf_awready", 64'(awready), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0;
    chk("wf_bvalid2", 64'(bvalid), 64'd1);
    chk("wf_regout", slice(5), 64'h5555_0000_5555_0000);
    finish_write(r);
    chk("wf_bresp", 64'(r), 64'd0);
    chk("wf_wready3", 64'(wready), 64'd1);

    // AW accepted 3 cycles before W (reg 6)
    @(negedge aclk);
    awvalid = 1; awaddr = 32'h30;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0;
    chk("af_awready", 64'(awready), 64'd0);
    repeat (2) @(negedge aclk);
    chk("af_bvalid", 64'(bvalid), 64'd0);
    wvalid = 1; wdata = 64'h6666_7777_8888_9999; wstrb = 8'hFF;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 0;
    chk("af_bvalid2", 64'(bvalid), 64'd1);
    finish_write(r);
    chk("af_bresp", 64'(r), 64'd0);
    start_read(32'h30);
    finish_read(d, r);
    chk("af_rdata", d, 64'h6666_7777_8888_9999);

    // Read-only reg 2
    start_write(32'h10, 64'h1234, 8'hFF);
    finish_write(r);
    chk("ro_bresp", 64'(r), 64'd2);
    chk("ro_regout", slice(2), 64'd0);
    start_read(32'h10);
    finish_read(d, r);
    chk("ro_rdata", d, 64'h0000_0000_0000_CAFE);
    chk("ro_rresp", 64'(r), 64'd0);

    // Pulse reg 3
    start_write(32'h18, 64'h5, 8'hFF);
    chk("pulse_hi", slice(3), 64'h5);
    finish_write(r);
    chk("pulse_clr", slice(3), 64'd0);
    chk("pulse_bresp", 64'(r), 64'd0);
    start_read(32'h18);
    finish_read(d, r);
    chk("pulse_rdata", d, 64'd0);

    // Out of range
    snap = reg_out;
    start_read(32'h80);
    finish_read(d, r);
    chk("dec_rdata", d, 64'd0);
    chk("dec_rresp", 64'(r), 64'd3);
    start_write(32'h80, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    finish_write(r);
    chk("dec_bresp", 64'(r), 64'd3);
    chk("dec_nochange", 64'(reg_out == snap), 64'd1);

    // Backpressure: responses held for 10 cycles
    start_read(32'h08);
    start_write(32'h38, 64'h77, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("bp_rvalid", 64'(rvalid), 64'd1);
      chk("bp_rdata", rdata, 64'h0123_4567_89AB_CDEF);
      chk("bp_rresp", 64'(rresp), 64'd0);
      chk("bp_bvalid", 64'(bvalid), 64'd1);
      chk("bp_bresp", 64'(bresp), 64'd0);
      chk("bp_arready", 64'(arready), 64'd0);
      chk("bp_awready", 64'(awready), 64'd0);
      chk("bp_wready", 64'(wready), 64'd0);
    end
    finish_read(d, r);
    finish_write(r);

    // Reset while both responses are pending
    start_read(32'h08);
    start_write(32'h40, 64'h99, 8'hFF);
    @(negedge aclk);
    rstn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("mr_rvalid", 64'(rvalid), 64'd0);
    chk("mr_bvalid", 64'(bvalid), 64'd0);
    chk("mr_regs", 64'(|reg_out), 64'd0);
    chk("mr_arready", 64'(arready), 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("mr_no_r", 64'(rvalid), 64'd0);
      chk("mr_no_b", 64'(bvalid), 64'd0);
    end
    start_read(32'h08);
    finish_read(d, r);
    chk("mr_rdata", d, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
